// File: rtl/restart_ctrl.sv
// System restart controller: merges button, watchdog, trap and software restart
// requests into a fixed-length active-low reset and records cause and count.
module restart_ctrl #(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  input  logic        wdog_trig,
  input  logic        trap_trig,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic        sys_rst_n,
  output logic [15:0] data_out
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_POWER = 3'd1;
  localparam logic [2:0] C_BTN   = 3'd2;
  localparam logic [2:0] C_WDOG  = 3'd3;
  localparam logic [2:0] C_TRAP  = 3'd4;
  localparam logic [2:0] C_SW    = 3'd5;

  typedef enum logic {HOLD, RUN} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      cause;
  logic [7:0]      count;
  logic            sync1, sync2;
  logic            db_level, db_prev;
  logic [DW-1:0]   db_cnt;
  logic            btn_event, sw_req, clr_req, any_event;
  logic [2:0]      event_code;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_event = db_level & ~db_prev;
  assign sw_req    = wr & data_in[0];
  assign clr_req   = wr & data_in[1];
  assign any_event = btn_event | wdog_trig | trap_trig | sw_req;

  always_comb begin
    event_code = C_NONE;
    if (btn_event)      event_code = C_BTN;
    else if (wdog_trig) event_code = C_WDOG;
    else if (trap_trig) event_code = C_TRAP;
    else if (sw_req)    event_code = C_SW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
      cause     <= C_POWER;
      count     <= 8'd0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (any_event) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            sys_rst_n <= 1'b0;
            cause     <= event_code;
            // A same-cycle clear is applied before the restart is counted.
            if (clr_req)             count <= 8'd1;
            else if (count != 8'hff) count <= count + 8'd1;
          end else if (clr_req) begin
            cause <= C_NONE;
            count <= 8'd0;
          end
        end
        default: begin
          state     <= HOLD;
          hold_cnt  <= '0;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = {count, 5'b0, cause};

endmodule

// File: tb/tb_restart_ctrl.sv
// Bench for restart_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue/arithmetic reference model.
module tb_restart_ctrl;

  localparam int HOLD = 16;
  localparam int DB   = 8;

  logic        clk;
  logic        rst;
  logic        btn_in;
  logic        wdog_trig;
  logic        trap_trig;
  logic        wr;
  logic [15:0] data_in;
  logic        sys_rst_n;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_falls = 0;
  logic last_rst_n = 1'b0;

  // Reference model state
  int         hold_left;
  logic [2:0] m_cause;
  logic [7:0] m_count;
  logic       pipe[$];
  logic       seen_q[$];
  logic       m_level;
  logic       m_btn_ev;
  logic [16:0] exp_q[$];

  restart_ctrl #(.HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .wdog_trig(wdog_trig),
    .trap_trig(trap_trig), .wr(wr), .data_in(data_in),
    .sys_rst_n(sys_rst_n), .data_out(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic ev, seen, flip;
    logic [2:0] code;
    if (rst) begin
      hold_left = HOLD;
      m_cause   = 3'd1;
      m_count   = 8'd0;
      pipe      = {1'b0, 1'b0};
      seen_q    = {};
      m_level   = 1'b0;
      m_btn_ev  = 1'b0;
    end else begin
      ev   = m_btn_ev;
      seen = pipe.pop_front();
      pipe.push_back(btn_in);
      seen_q.push_back(seen);
      if (seen_q.size() > DB) void'(seen_q.pop_front());
      flip = (seen_q.size() == DB);
      foreach (seen_q[i]) if (seen_q[i] == m_level) flip = 1'b0;
      if (flip) m_level = ~m_level;
      m_btn_ev = flip && m_level;
      if (hold_left > 0) begin
        hold_left--;
      end else begin
        code = 3'd0;
        if (ev)                     code = 3'd2;
        else if (wdog_trig)         code = 3'd3;
        else if (trap_trig)         code = 3'd4;
        else if (wr && data_in[0])  code = 3'd5;
        if (wr && data_in[1]) begin
          m_cause = 3'd0;
          m_count = 8'd0;
        end
        if (code != 3'd0) begin
          m_cause   = code;
          m_count   = (m_count == 8'd255) ? 8'd255 : m_count + 8'd1;
          hold_left = HOLD;
        end
      end
    end
    exp_q.push_back({(hold_left == 0), m_count, 5'b0, m_cause});
  endtask

  task automatic tick();
    logic [16:0] e;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    e = exp_q.pop_front();
    check("rst_n", {15'b0, sys_rst_n}, {15'b0, e[16]});
    check("dout", data_out, e[15:0]);
    if (last_rst_n && !sys_rst_n) n_falls++;
    last_rst_n = sys_rst_n;
  endtask

  task automatic sw_write(input logic [15:0] d);
    wr = 1'b1;
    data_in = d;
    tick();
    wr = 1'b0;
    data_in = 16'h0;
  endtask

  // Ticks until sys_rst_n is high, bounded; returns number of ticks taken.
  task automatic wait_release(output int n);
    n = 0;
    while (!sys_rst_n && n < 100) begin
      tick();
      n++;
    end
    if (!sys_rst_n) check("release_timeout", {15'b0, sys_rst_n}, 16'h0001);
  endtask

  initial begin
    int n, rise_cyc, fall_cyc, falls0;
    rst = 1'b1; btn_in = 1'b0; wdog_trig = 1'b0; trap_trig = 1'b0;
    wr = 1'b0; data_in = 16'h0;

    // Power-on
    repeat (3) tick();
    check("por_rst_n", {15'b0, sys_rst_n}, 16'h0000);
    check("por_dout", data_out, 16'h0001);
    rst = 1'b0;
    wait_release(n);
    check("por_len", 16'(n), 16'd16);
    repeat (3) tick();

    // Software restart
    sw_write(16'h0001);
    check("sw_rst_n", {15'b0, sys_rst_n}, 16'h0000);
    check("sw_dout", data_out, 16'h0105);
    wait_release(n);
    check("sw_len", 16'(n), 16'd16);
    repeat (2) tick();

    // Simultaneous events, then a trap pulse inside HOLD
    wdog_trig = 1'b1; trap_trig = 1'b1;
    sw_write(16'h0001);
    wdog_trig = 1'b0; trap_trig = 1'b0;
    check("simul_dout", data_out, 16'h0203);
    repeat (4) tick();
    trap_trig = 1'b1; tick(); trap_trig = 1'b0;
    wait_release(n);
    tick();
    check("hold_trap_dout", data_out, 16'h0203);

    // Button bounce
    repeat (10) tick();
    falls0 = n_falls;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_in = ~btn_in;
      tick();
    end
    btn_in = 1'b1;
    tick();
    rise_cyc = cyc;
    fall_cyc = -1;
    for (int i = 0; i < 40 && fall_cyc < 0; i++) begin
      tick();
      if (!sys_rst_n) fall_cyc = cyc;
    end
    check("btn_lat", 16'(fall_cyc - rise_cyc), 16'd10);
    check("btn_cause", {13'b0, data_out[2:0]}, 16'd2);
    wait_release(n);
    btn_in = 1'b0;
    repeat (20) tick();
    check("btn_restarts", 16'(n_falls - falls0), 16'd1);

    // Count saturation and clear
    for (int i = 0; i < 256; i++) begin
      sw_write(16'h0001);
      wait_release(n);
    end
    check("sat_count", {8'b0, data_out[15:8]}, 16'd255);
    sw_write(16'h0002);
    check("clear_dout", data_out, 16'h0000);
    sw_write(16'h0003);
    check("clr_restart_dout", data_out, 16'h0105);
    wait_release(n);
    tick();

    // Reset in the middle of HOLD
    sw_write(16'h0001);
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midhold_dout", data_out, 16'h0001);
    wait_release(n);
    check("midhold_len", 16'(n), 16'd16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_in = ~btn_in;
      wdog_trig = ($urandom_range(0, 39) == 0);
      trap_trig = ($urandom_range(0, 39) == 0);
      wr        = ($urandom_range(0, 9) == 0);
      data_in   = 16'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; wr = 1'b0; wdog_trig = 1'b0; trap_trig = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
